counter_nbit_updn: RTL and testbench



---
 rtl/counter_nbit_updn_pkg.sv | 15 +
 rtl/counter_nbit_updn_reg.sv | 24 ++
 rtl/counter_nbit_updn.sv | 94 +++++++++
 tb/tb_counter_nbit_updn.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/counter_nbit_updn_pkg.sv
// Shared encodings and defaults for the up/down modulus counter.
// Imported by the counter top level and its datapath register.
package counter_nbit_updn_pkg;

    localparam int DEF_WIDTH = 4;

    // Direction encodings (up_dn)
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Boundary mode encodings (sat_mode)
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_nbit_updn_reg.sv
// counter_reg: WIDTH-bit datapath register, sync reset to RESET_VAL.
// Ports: clk, reset (sync, active-high), ld (update enable), d, q.
module counter_reg
    import counter_nbit_updn_pkg::*;
#(
    parameter int              WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/counter_nbit_updn.sv
// Up/down counter over [0..MAX] with load, enable, wrap or saturate.
// Ports: clk, reset, en, up_dn, sat_mode, load, load_val -> count, tc, wrap, sat.
module counter_nbit_updn
    import counter_nbit_updn_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    logic             at_max;
    logic             at_zero;
    logic             reg_ld;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign at_max  = (count == MAX);
    assign at_zero = (count == '0);

    assign tc = ((up_dn == DIR_UP) && at_max) ||
                ((up_dn == DIR_DN) && at_zero);

    always_comb begin
        nxt      = count;
        reg_ld   = 1'b0;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (load) begin
            // Out-of-range loads clamp to MAX rather than truncating
            nxt    = (load_val > MAX) ? MAX : load_val;
            reg_ld = 1'b1;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (!at_max) begin
                    nxt    = count + 1'b1;
                    reg_ld = 1'b1;
                end else if (sat_mode == MODE_SAT) begin
                    sat_nxt = 1'b1;
                end else begin
                    nxt      = '0;
                    reg_ld   = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    nxt    = count - 1'b1;
                    reg_ld = 1'b1;
                end else if (sat_mode == MODE_SAT) begin
                    sat_nxt = 1'b1;
                end else begin
                    nxt      = MAX;
                    reg_ld   = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    counter_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .ld    (reg_ld),
        .d     (nxt),
        .q     (count)
    );

    // Status flags are single-edge pulses/levels; any other edge clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_counter_nbit_updn.sv
// Directed self-checking bench for counter_nbit_updn.
// Covers a decade counter (W=4, MAX=9) and a full-range 8-bit counter.
module tb_counter_nbit_updn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Decade instance
    logic       a_reset, a_en, a_up, a_satm, a_load;
    logic [3:0] a_lv, a_count;
    logic       a_tc, a_wrap, a_sat;

    // Full-range instance
    logic       b_reset, b_en, b_up, b_satm, b_load;
    logic [7:0] b_lv, b_count;
    logic       b_tc, b_wrap, b_sat;

    counter_nbit_updn #(
        .WIDTH     (4),
        .MAX       (4'd9),
        .RESET_VAL (4'd0)
    ) dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .en       (a_en),
        .up_dn    (a_up),
        .sat_mode (a_satm),
        .load     (a_load),
        .load_val (a_lv),
        .count    (a_count),
        .tc       (a_tc),
        .wrap     (a_wrap),
        .sat      (a_sat)
    );

    counter_nbit_updn #(
        .WIDTH     (8),
        .MAX       (8'd255),
        .RESET_VAL (8'd0)
    ) dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .en       (b_en),
        .up_dn    (b_up),
        .sat_mode (b_satm),
        .load     (b_load),
        .load_val (b_lv),
        .count    (b_count),
        .tc       (b_tc),
        .wrap     (b_wrap),
        .sat      (b_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int b_wraps;

    initial begin
        a_reset = 1'b1; a_en = 1'b0; a_up = 1'b1; a_satm = 1'b0;
        a_load  = 1'b0; a_lv = 4'd0;
        b_reset = 1'b1; b_en = 1'b0; b_up = 1'b1; b_satm = 1'b0;
        b_load  = 1'b0; b_lv = 8'd0;

        // Reset state
        step();
        chk("rst_count", a_count, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_tc_up", a_tc, 0);

        // Up, wrap mode: 0,1..9,0,1
        a_reset = 1'b0; a_en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk($sformatf("up_count_%0d", i), a_count, i % 10);
            chk($sformatf("up_tc_%0d", i), a_tc, (i % 10) == 9);
            chk($sformatf("up_wrap_%0d", i), a_wrap, i == 10);
        end

        // Down, wrap mode from reset: 0,9,8
        a_reset = 1'b1;
        step();
        a_reset = 1'b0; a_up = 1'b0;
        #1;
        chk("dn_tc_zero", a_tc, 1);
        step();
        chk("dn_count_9", a_count, 9);
        chk("dn_wrap_9", a_wrap, 1);
        chk("dn_tc_9", a_tc, 0);
        step();
        chk("dn_count_8", a_count, 8);
        chk("dn_wrap_8", a_wrap, 0);

        // Saturate up from 8
        a_load = 1'b1; a_lv = 4'd8; a_up = 1'b1; a_en = 1'b0;
        step();
        chk("ld_8", a_count, 8);
        a_load = 1'b0; a_satm = 1'b1; a_en = 1'b1;
        step();
        chk("sat_c1", a_count, 9);
        chk("sat_f1", a_sat, 0);
        chk("sat_tc1", a_tc, 1);
        step();
        chk("sat_c2", a_count, 9);
        chk("sat_f2", a_sat, 1);
        step();
        chk("sat_c3", a_count, 9);
        chk("sat_f3", a_sat, 1);
        chk("sat_wrap3", a_wrap, 0);
        a_en = 1'b0;
        step();
        chk("sat_off_c", a_count, 9);
        chk("sat_off_f", a_sat, 0);

        // Load clamp and load priority over en
        a_satm = 1'b0; a_load = 1'b1; a_lv = 4'd13;
        step();
        chk("ld_clamp", a_count, 9);
        a_en = 1'b1; a_lv = 4'd3;
        step();
        chk("ld_wins", a_count, 3);
        a_load = 1'b0;
        for (int i = 4; i <= 7; i++) begin
            step();
            chk($sformatf("run_%0d", i), a_count, i);
        end

        // Reset beats load and en
        a_reset = 1'b1; a_load = 1'b1; a_lv = 4'd5;
        step();
        chk("rst_pri_c", a_count, 0);
        chk("rst_pri_w", a_wrap, 0);
        chk("rst_pri_s", a_sat, 0);
        a_reset = 1'b0; a_load = 1'b0; a_en = 1'b0;

        // Full-range 8-bit: 256 steps back to 0, one wrap
        chk("b_rst_c", b_count, 0);
        chk("b_rst_tc", b_tc, 0);
        chk("b_rst_s", b_sat, 0);
        b_reset = 1'b0; b_en = 1'b1;
        b_wraps = 0;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (b_wrap) b_wraps++;
        end
        chk("b_full_c", b_count, 0);
        chk("b_full_wraps", b_wraps, 1);
        for (int i = 1; i <= 128; i++) step();
        chk("b_mid_c", b_count, 128);
        b_up = 1'b0;
        step();
        chk("b_flip_c", b_count, 127);
        chk("b_flip_w", b_wrap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
